mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction / data) arbiter in front of a single shared
//            RAM with a stall handshake.  One access is in flight at a time.
//            Ties alternate between the ports, and a wait counter forces
//            completion of accesses that stall for too long.
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            i_cs/i_we/i_addr/i_din      - instruction-port request
//            i_dout/i_stall              - instruction-port read data / stall
//            d_cs/d_we/d_addr/d_din      - data-port request
//            d_dout/d_stall              - data-port read data / stall
//            ram_cs/ram_we/ram_addr/ram_din - shared-RAM request
//            ram_dout/ram_stall          - shared-RAM read data / busy
//            err                         - sticky timeout flag
// Params   : TIMEOUT - maximum BUSY cycles before forced completion (2..255)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cs,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_din,
   output logic [31:0] i_dout,
   output logic        i_stall,
   input  logic        d_cs,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_din,
   output logic [31:0] d_dout,
   output logic        d_stall,
   output logic        ram_cs,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout,
   input  logic        ram_stall,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BUSY_I = 3'd1,
      S_BUSY_D = 3'd2,
      S_DONE_I = 3'd3,
      S_DONE_D = 3'd4
   } state_t;

   // Wait count at which a still-stalled access is forcibly completed.
   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

   state_t      state_q,  state_d;
   logic        we_q,     we_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] din_q,    din_d;
   logic [31:0] i_dout_q, i_dout_d;
   logic [31:0] d_dout_q, d_dout_d;
   logic        err_q,    err_d;
   logic [7:0]  wait_q,   wait_d;
   logic        last_d_q, last_d_d;

   logic        busy;
   logic        busy_is_d;
   logic        grant_d;

   assign busy      = (state_q == S_BUSY_I) || (state_q == S_BUSY_D);
   assign busy_is_d = (state_q == S_BUSY_D);

   // On a tie the port that was NOT served last wins; last_d_q resets to 0
   // so the data port wins the very first tie.
   assign grant_d   = d_cs && (!i_cs || !last_d_q);

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      din_d    = din_q;
      i_dout_d = i_dout_q;
      d_dout_d = d_dout_q;
      err_d    = err_q;
      wait_d   = wait_q;
      last_d_d = last_d_q;

      case (state_q)
         S_IDLE: begin
            if (grant_d) begin
               state_d = S_BUSY_D;
               we_d    = d_we;
               addr_d  = d_addr;
               din_d   = d_din;
            end else if (i_cs) begin
               state_d = S_BUSY_I;
               we_d    = i_we;
               addr_d  = i_addr;
               din_d   = i_din;
            end
         end

         S_BUSY_I, S_BUSY_D: begin
            if (!ram_stall || (wait_q == WAIT_LIMIT)) begin
               // Normal or forced completion.  A forced completion also
               // counts as "served" for tie-breaking so a dead RAM cannot
               // starve one port.
               state_d  = busy_is_d ? S_DONE_D : S_DONE_I;
               last_d_d = busy_is_d;
               wait_d   = 8'd0;
               if (ram_stall) begin
                  err_d = 1'b1;
               end
               if (busy_is_d) begin
                  d_dout_d = ram_stall ? 32'h0 : ram_dout;
               end else begin
                  i_dout_d = ram_stall ? 32'h0 : ram_dout;
               end
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         S_DONE_I, S_DONE_D: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         addr_q   <= 32'h0;
         din_q    <= 32'h0;
         i_dout_q <= 32'h0;
         d_dout_q <= 32'h0;
         err_q    <= 1'b0;
         wait_q   <= 8'd0;
         last_d_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         i_dout_q <= i_dout_d;
         d_dout_q <= d_dout_d;
         err_q    <= err_d;
         wait_q   <= wait_d;
         last_d_q <= last_d_d;
      end
   end

   assign ram_cs   = busy;
   assign ram_we   = we_q & busy;
   assign ram_addr = addr_q;
   assign ram_din  = din_q;
   assign i_dout   = i_dout_q;
   assign d_dout   = d_dout_q;
   assign err      = err_q;

   // A port stalls whenever it requests, except in its own DONE cycle.
   assign i_stall  = i_cs & (state_q != S_DONE_I);
   assign d_stall  = d_cs & (state_q != S_DONE_D);

endmodule
`default_nettype wire
